// File: rtl/arp_cache.sv
// IPv4->MAC learning cache: FIFO-buffered learn path into a round-robin register table, plus a scanning lookup port.
// Latency: a lookup hit at index k lands k+2 edges after the request change; a miss pulses arp_err N+1 edges after it.
// Backpressure: none upstream; learn pairs arriving while the FIFO is full are dropped and flagged on fifo_ovf.

module fifo_sc #(
    parameter int AW = 8,
    parameter int DW = 80
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_dat,
    input  logic          pop,
    output logic [DW-1:0] pop_dat,
    output logic          full,
    output logic          empty
);
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [DW-1:0] mem [2**AW];
    logic          do_push;
    logic          do_pop;

    // Extra pointer bit tells full from empty when the low bits coincide.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            pop_dat <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                pop_dat <= mem[rd_ptr[AW-1:0]];
            end
        end
    end
endmodule

module arp_cache #(
    parameter int FIFO_AW = 8,
    parameter int TBL_AW  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_val,
    input  logic [31:0] in_ipv4,
    input  logic [47:0] in_mac,
    input  logic [31:0] ipv4_req,
    output logic [47:0] mac_rsp,
    output logic        arp_val,
    output logic        arp_err,
    output logic        fifo_ovf
);
    localparam int N = 2**TBL_AW;
    localparam logic [TBL_AW-1:0] LAST = '1;

    typedef enum logic [2:0] {W_IDLE, W_POP, W_SCAN, W_UPD, W_ADD} w_state_t;
    typedef enum logic       {R_IDLE, R_SCAN} r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic [N-1:0]      tbl_vld;
    logic [31:0]       tbl_ip  [N];
    logic [47:0]       tbl_mac [N];
    logic [TBL_AW-1:0] w_ptr;
    logic [TBL_AW-1:0] idx;
    logic [TBL_AW-1:0] ridx;
    logic [31:0]       wr_ip;
    logic [47:0]       wr_mac;
    logic [31:0]       req_reg;

    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [79:0]       fifo_dat;
    logic              scan_hit;
    logic              req_hit;
    logic              req_start;

    fifo_sc #(.AW(FIFO_AW), .DW(80)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (in_val),
        .push_dat ({in_ipv4, in_mac}),
        .pop      (fifo_pop),
        .pop_dat  (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign fifo_pop  = (w_state == W_IDLE) && !fifo_empty;
    assign scan_hit  = tbl_vld[idx] && (tbl_ip[idx] == wr_ip);
    assign req_hit   = tbl_vld[ridx] && (tbl_ip[ridx] == req_reg);
    assign req_start = (ipv4_req != req_reg) && (ipv4_req != 32'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fifo_ovf <= 1'b0;
        end else begin
            fifo_ovf <= in_val && fifo_full;
        end
    end

    // ---------------- write side ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state <= W_IDLE;
        end else begin
            w_state <= w_next;
        end
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE: if (!fifo_empty) w_next = W_POP;
            W_POP:  w_next = W_SCAN;
            W_SCAN: begin
                if (scan_hit) begin
                    w_next = W_UPD;
                end else if (idx == LAST) begin
                    w_next = W_ADD;
                end
            end
            W_UPD:  w_next = W_IDLE;
            W_ADD:  w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tbl_vld <= '0;
            w_ptr   <= '0;
            idx     <= '0;
            wr_ip   <= '0;
            wr_mac  <= '0;
            for (int i = 0; i < N; i++) begin
                tbl_ip[i]  <= '0;
                tbl_mac[i] <= '0;
            end
        end else begin
            case (w_state)
                W_POP: begin
                    wr_ip  <= fifo_dat[79:48];
                    wr_mac <= fifo_dat[47:0];
                    idx    <= '0;
                end
                W_SCAN: begin
                    if (!scan_hit && idx != LAST) begin
                        idx <= idx + TBL_AW'(1);
                    end
                end
                W_UPD: begin
                    tbl_mac[idx] <= wr_mac;
                end
                W_ADD: begin
                    // Round-robin slot: once the table is full this evicts the oldest add.
                    tbl_ip[w_ptr]  <= wr_ip;
                    tbl_mac[w_ptr] <= wr_mac;
                    tbl_vld[w_ptr] <= 1'b1;
                    w_ptr          <= w_ptr + TBL_AW'(1);
                end
                default: ;
            endcase
        end
    end

    // ---------------- lookup side ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_next;
        end
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE: if (req_start) r_next = R_SCAN;
            R_SCAN: if (req_hit || ridx == LAST) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_reg <= '0;
            ridx    <= '0;
            mac_rsp <= '0;
            arp_val <= 1'b0;
            arp_err <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    arp_err <= 1'b0;
                    req_reg <= ipv4_req;
                    if (req_start) begin
                        arp_val <= 1'b0;
                        ridx    <= '0;
                    end
                end
                R_SCAN: begin
                    // req_reg is frozen here, so request changes mid-scan wait for R_IDLE.
                    if (req_hit) begin
                        mac_rsp <= tbl_mac[ridx];
                        arp_val <= 1'b1;
                    end else if (ridx == LAST) begin
                        arp_err <= 1'b1;
                    end else begin
                        ridx <= ridx + TBL_AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_arp_cache.sv
// Directed bench for arp_cache: learn/update/evict, lookup latency, overflow drops and async reset.
module tb_arp_cache;
    logic        clk;
    logic        rst;
    logic        in_val;
    logic [31:0] in_ipv4;
    logic [47:0] in_mac;
    logic [31:0] ipv4_req;
    logic [47:0] mac_rsp;
    logic        arp_val;
    logic        arp_err;
    logic        fifo_ovf;

    int checks   = 0;
    int failures = 0;

    arp_cache #(.FIFO_AW(8), .TBL_AW(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_val   (in_val),
        .in_ipv4  (in_ipv4),
        .in_mac   (in_mac),
        .ipv4_req (ipv4_req),
        .mac_rsp  (mac_rsp),
        .arp_val  (arp_val),
        .arp_err  (arp_err),
        .fifo_ovf (fifo_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic do_reset();
        rst      = 1'b0;
        in_val   = 1'b0;
        in_ipv4  = '0;
        in_mac   = '0;
        ipv4_req = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic learn(input logic [31:0] ip, input logic [47:0] mac);
        in_val  = 1'b1;
        in_ipv4 = ip;
        in_mac  = mac;
        @(posedge clk); #1;
        in_val  = 1'b0;
    endtask

    // Applies a request and records the edge (1 = edge that sees the change) of the first arp_val / arp_err.
    task automatic run_lookup(input logic [31:0] ip, output int hit_edge, output int err_edge,
                              output int err_cnt, output logic [47:0] mac);
        hit_edge = -1;
        err_edge = -1;
        err_cnt  = 0;
        mac      = '0;
        ipv4_req = ip;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk); #1;
            if (arp_val && hit_edge < 0) begin
                hit_edge = e;
                mac      = mac_rsp;
            end
            if (arp_err) begin
                err_cnt++;
                if (err_edge < 0) err_edge = e;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_val = 1'b0; in_ipv4 = '0; in_mac = '0; ipv4_req = '0;
        #3 rst = 1'b0;
        #1;
        checks++;
        if ({arp_val, arp_err, fifo_ovf} !== 3'b000 || mac_rsp !== 48'd0) begin
            failures++;
            $display("FAIL reset_outputs: val/err/ovf=%b%b%b mac=%h, required 000 and 0", arp_val, arp_err, fifo_ovf, mac_rsp);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_hit();
        int h, e, c; logic [47:0] m;
        do_reset();
        learn(32'h0A000001, 48'h020000000001);
        idle(20);
        run_lookup(32'h0A000001, h, e, c, m);
        checks++;
        if (h !== 2) begin
            failures++; $display("FAIL basic_hit_edge: got %0d, required 2", h);
        end
        checks++;
        if (m !== 48'h020000000001) begin
            failures++; $display("FAIL basic_hit_mac: got %h, required 020000000001", m);
        end
        checks++;
        if (c !== 0) begin
            failures++; $display("FAIL basic_hit_err: got %0d pulses, required 0", c);
        end
        checks++;
        if (arp_val !== 1'b1 || mac_rsp !== 48'h020000000001) begin
            failures++; $display("FAIL basic_hold: val=%b mac=%h, required 1 020000000001", arp_val, mac_rsp);
        end
    endtask

    task automatic test_update();
        int h, e, c; logic [47:0] m;
        do_reset();
        learn(32'h0A000001, 48'h020000000001);
        idle(20);
        learn(32'h0A000001, 48'h0200000000AA);
        idle(20);
        run_lookup(32'h0A000001, h, e, c, m);
        checks++;
        if (h !== 2 || m !== 48'h0200000000AA) begin
            failures++; $display("FAIL update_hit: edge=%0d mac=%h, required 2 0200000000aa", h, m);
        end
        // A fresh IP must land in slot 1, proving the update did not advance the add pointer.
        learn(32'h0A000002, 48'h020000000002);
        idle(20);
        run_lookup(32'h0A000002, h, e, c, m);
        checks++;
        if (h !== 3 || m !== 48'h020000000002) begin
            failures++; $display("FAIL update_wptr: edge=%0d mac=%h, required 3 020000000002", h, m);
        end
    endtask

    task automatic test_evict();
        int h, e, c; logic [47:0] m;
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            learn(32'h0A000100 + 32'(i), 48'h020000000100 + 48'(i));
        end
        idle(130);
        run_lookup(32'h0A000101, h, e, c, m);
        checks++;
        if (h !== -1 || e !== 9 || c !== 1) begin
            failures++; $display("FAIL evict_first_miss: hit=%0d err_edge=%0d pulses=%0d, required -1 9 1", h, e, c);
        end
        checks++;
        if (arp_val !== 1'b0) begin
            failures++; $display("FAIL evict_val_low: got %b, required 0", arp_val);
        end
        run_lookup(32'h0A000109, h, e, c, m);
        checks++;
        if (h !== 2 || m !== 48'h020000000109) begin
            failures++; $display("FAIL evict_ninth: edge=%0d mac=%h, required 2 020000000109", h, m);
        end
        run_lookup(32'h0A000102, h, e, c, m);
        checks++;
        if (h !== 3 || m !== 48'h020000000102) begin
            failures++; $display("FAIL evict_second: edge=%0d mac=%h, required 3 020000000102", h, m);
        end
    endtask

    task automatic test_empty_miss();
        int h, e, c; logic [47:0] m;
        do_reset();
        run_lookup(32'hC0A80107, h, e, c, m);
        checks++;
        if (e !== 9 || c !== 1 || h !== -1) begin
            failures++; $display("FAIL empty_miss: err_edge=%0d pulses=%0d hit=%0d, required 9 1 -1", e, c, h);
        end
        run_lookup(32'hC0A80107, h, e, c, m);
        checks++;
        if (c !== 0 || h !== -1) begin
            failures++; $display("FAIL repeat_no_retrigger: pulses=%0d hit=%0d, required 0 -1", c, h);
        end
        run_lookup(32'h00000000, h, e, c, m);
        checks++;
        if (c !== 0 || h !== -1) begin
            failures++; $display("FAIL zero_req: pulses=%0d hit=%0d, required 0 -1", c, h);
        end
    endtask

    // Distinct IPs keep each drain at 11 cycles, so pops land on edges 2, 13, 24, ...;
    // the FIFO first holds 256 after push 282, giving drops on pushes 283-288 and 290-299.
    task automatic test_overflow();
        int ovf_cnt, first_ovf, h, e, c; logic [47:0] m;
        ovf_cnt   = 0;
        first_ovf = -1;
        do_reset();
        for (int i = 1; i <= 300; i++) begin
            in_val  = 1'b1;
            in_ipv4 = 32'h0B000000 + 32'(i);
            in_mac  = 48'h020000000000 + 48'(i);
            @(posedge clk); #1;
            if (fifo_ovf) begin
                ovf_cnt++;
                if (first_ovf < 0) first_ovf = i;
            end
        end
        in_val = 1'b0;
        @(posedge clk); #1;
        if (fifo_ovf) ovf_cnt++;
        checks++;
        if (ovf_cnt !== 16) begin
            failures++; $display("FAIL ovf_count: got %0d, required 16", ovf_cnt);
        end
        checks++;
        if (first_ovf !== 283) begin
            failures++; $display("FAIL ovf_first: got push %0d, required 283", first_ovf);
        end
        idle(3300);
        run_lookup(32'h0B000000 + 32'd300, h, e, c, m);
        checks++;
        if (h !== 5 || m !== 48'h02000000012C) begin
            failures++; $display("FAIL ovf_last_kept: edge=%0d mac=%h, required 5 02000000012c", h, m);
        end
        run_lookup(32'h0B000000 + 32'd289, h, e, c, m);
        checks++;
        if (h !== 4 || m !== 48'h020000000121) begin
            failures++; $display("FAIL ovf_289_kept: edge=%0d mac=%h, required 4 020000000121", h, m);
        end
        run_lookup(32'h0B000000 + 32'd283, h, e, c, m);
        checks++;
        if (h !== -1 || e !== 9) begin
            failures++; $display("FAIL ovf_dropped_absent: hit=%0d err_edge=%0d, required -1 9", h, e);
        end
    endtask

    task automatic test_reset_mid_scan();
        int h, e, c; logic [47:0] m;
        do_reset();
        learn(32'h0A000005, 48'h020000000005);
        idle(20);
        run_lookup(32'h0A000005, h, e, c, m);
        checks++;
        if (h !== 2) begin
            failures++; $display("FAIL pre_reset_hit: edge=%0d, required 2", h);
        end
        ipv4_req = 32'h0A000009;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        ipv4_req = '0;
        #1;
        checks++;
        if ({arp_val, arp_err, fifo_ovf} !== 3'b000 || mac_rsp !== 48'd0) begin
            failures++; $display("FAIL reset_mid_scan: val/err/ovf=%b%b%b mac=%h, required 000 and 0", arp_val, arp_err, fifo_ovf, mac_rsp);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        run_lookup(32'h0A000005, h, e, c, m);
        checks++;
        if (h !== -1 || e !== 9) begin
            failures++; $display("FAIL post_reset_miss: hit=%0d err_edge=%0d, required -1 9", h, e);
        end
    endtask

    initial begin
        test_reset();
        test_basic_hit();
        test_update();
        test_evict();
        test_empty_miss();
        test_overflow();
        test_reset_mid_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
